// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the alarm controller and its surroundings: BCD time in,
// user controls in, alarm time and status flags out.
interface alarm_ctrl_if;
    logic       tick;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       arm;
    logic       set_en;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic       set_pm;
    logic       snooze;
    logic       stop;
    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;
    logic       alarm_pm;
    logic       armed;
    logic       ringing;
    logic       snoozing;
    logic       buzz;
    logic       set_err;

    modport master (
        output tick, hh, mm, ss, pm, arm, set_en, set_hh, set_mm, set_pm, snooze, stop,
        input  alarm_hh, alarm_mm, alarm_pm, armed, ringing, snoozing, buzz, set_err
    );

    modport slave (
        input  tick, hh, mm, ss, pm, arm, set_en, set_hh, set_mm, set_pm, snooze, stop,
        output alarm_hh, alarm_mm, alarm_pm, armed, ringing, snoozing, buzz, set_err
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller for the 12-hour clock core: stores the alarm time and runs
// the armed / ringing / snooze sequence driving the buzzer.
//
// state   | meaning
// IDLE    | alarm disabled (arm=0), alarm time may be set
// ARMED   | waiting for the rising edge of a time match
// RINGING | buzzer toggling once per tick until timeout, stop or snooze
// SNOOZE  | counting down snooze ticks before ringing again
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CNT_W       = 9
) (
    input  logic         clk,
    input  logic         reset,
    alarm_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             buzz_q, buzz_nxt;
    logic             match, match_q, trigger;
    logic             set_ok, set_open;
    logic [7:0]       alarm_hh_q, alarm_mm_q;
    logic             alarm_pm_q;
    logic             armed_q, ringing_q, snoozing_q, set_err_q;

    function automatic logic hh_valid(input logic [7:0] v);
        return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
               ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    endfunction

    function automatic logic mm_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    assign match   = (bus.hh == alarm_hh_q) && (bus.mm == alarm_mm_q) &&
                     (bus.pm == alarm_pm_q) && (bus.ss == 8'h00);
    assign trigger = match & ~match_q;

    assign set_open = (state_q == IDLE) || (state_q == ARMED);
    assign set_ok   = hh_valid(bus.set_hh) && mm_valid(bus.set_mm);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        buzz_nxt  = buzz_q;
        if (!bus.arm) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            buzz_nxt  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_nxt = ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        state_nxt = RINGING;
                        cnt_nxt   = '0;
                        buzz_nxt  = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.stop) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                        buzz_nxt  = 1'b0;
                    end else if (bus.snooze) begin
                        state_nxt = SNOOZE;
                        cnt_nxt   = SNOOZE_LOAD;
                        buzz_nxt  = 1'b0;
                    end else if (bus.tick) begin
                        // The ring lasts exactly RING_SECS ticks from the trigger.
                        if (cnt_q == RING_LAST) begin
                            state_nxt = ARMED;
                            cnt_nxt   = '0;
                            buzz_nxt  = 1'b0;
                        end else begin
                            cnt_nxt  = cnt_q + CNT_ONE;
                            buzz_nxt = ~buzz_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                        buzz_nxt  = 1'b0;
                    end else if (bus.tick) begin
                        if (cnt_q == CNT_ONE) begin
                            state_nxt = RINGING;
                            cnt_nxt   = '0;
                            buzz_nxt  = 1'b1;
                        end else if (cnt_q != '0) begin
                            cnt_nxt = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    buzz_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buzz_q     <= 1'b0;
            match_q    <= 1'b0;
            armed_q    <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            set_err_q  <= 1'b0;
            alarm_hh_q <= 8'h12;
            alarm_mm_q <= 8'h00;
            alarm_pm_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            buzz_q     <= buzz_nxt;
            match_q    <= match;
            // Flags follow the next state so they line up with state_q.
            armed_q    <= (state_nxt != IDLE);
            ringing_q  <= (state_nxt == RINGING);
            snoozing_q <= (state_nxt == SNOOZE);
            set_err_q  <= bus.set_en && set_open && !set_ok;
            if (bus.set_en && set_open && set_ok) begin
                alarm_hh_q <= bus.set_hh;
                alarm_mm_q <= bus.set_mm;
                alarm_pm_q <= bus.set_pm;
            end
        end
    end

    assign bus.alarm_hh = alarm_hh_q;
    assign bus.alarm_mm = alarm_mm_q;
    assign bus.alarm_pm = alarm_pm_q;
    assign bus.armed    = armed_q;
    assign bus.ringing  = ringing_q;
    assign bus.snoozing = snoozing_q;
    assign bus.buzz     = buzz_q;
    assign bus.set_err  = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short ring/snooze lengths.
module tb_alarm_ctrl;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alarm_ctrl_if bus();

    alarm_ctrl #(
        .RING_SECS  (4),
        .SNOOZE_SECS(3),
        .CNT_W      (9)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic p);
        bus.hh = h;
        bus.mm = m;
        bus.ss = s;
        bus.pm = p;
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic p);
        bus.set_hh = h;
        bus.set_mm = m;
        bus.set_pm = p;
        bus.set_en = 1'b1;
        cyc();
        bus.set_en = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    // Produce a fresh rising edge of the 07:30:00 AM match.
    task automatic retrigger(input string tag);
        set_time(8'h07, 8'h29, 8'h59, 1'b0);
        cyc();
        set_time(8'h07, 8'h30, 8'h00, 1'b0);
        cyc();
        chk(tag, 32'(bus.ringing), 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        bus.tick   = 1'b0;
        bus.arm    = 1'b0;
        bus.set_en = 1'b0;
        bus.set_hh = 8'h00;
        bus.set_mm = 8'h00;
        bus.set_pm = 1'b0;
        bus.snooze = 1'b0;
        bus.stop   = 1'b0;
        set_time(8'h01, 8'h00, 8'h00, 1'b0);
        #12;
        chk("rst_armed",    32'(bus.armed),    32'd0);
        chk("rst_ringing",  32'(bus.ringing),  32'd0);
        chk("rst_buzz",     32'(bus.buzz),     32'd0);
        chk("rst_set_err",  32'(bus.set_err),  32'd0);
        chk("rst_alarm_hh", 32'(bus.alarm_hh), 32'h12);
        chk("rst_alarm_mm", 32'(bus.alarm_mm), 32'h00);
        chk("rst_alarm_pm", 32'(bus.alarm_pm), 32'd0);
        reset = 1'b1;
        cyc();

        do_set(8'h13, 8'h00, 1'b0);
        chk("bad_hh_err",  32'(bus.set_err),  32'd1);
        chk("bad_hh_keep", 32'(bus.alarm_hh), 32'h12);
        cyc();
        chk("err_one_cyc", 32'(bus.set_err),  32'd0);
        do_set(8'h07, 8'h5A, 1'b0);
        chk("bad_mm_err",  32'(bus.set_err),  32'd1);
        chk("bad_mm_keep", 32'(bus.alarm_mm), 32'h00);
        chk("bad_mm_hh",   32'(bus.alarm_hh), 32'h12);
        do_set(8'h00, 8'h10, 1'b0);
        chk("hh00_err",    32'(bus.set_err),  32'd1);
        do_set(8'h07, 8'h30, 1'b0);
        chk("ok_err",      32'(bus.set_err),  32'd0);
        chk("ok_hh",       32'(bus.alarm_hh), 32'h07);
        chk("ok_mm",       32'(bus.alarm_mm), 32'h30);
        chk("ok_pm",       32'(bus.alarm_pm), 32'd0);

        bus.arm = 1'b1;
        cyc();
        chk("arm_armed", 32'(bus.armed), 32'd1);
        set_time(8'h07, 8'h29, 8'h59, 1'b0);
        cyc();
        chk("pre_match", 32'(bus.ringing), 32'd0);
        set_time(8'h07, 8'h30, 8'h00, 1'b1);
        cyc();
        chk("pm_nomatch", 32'(bus.ringing), 32'd0);
        set_time(8'h07, 8'h30, 8'h00, 1'b0);
        cyc();
        chk("ring_start", 32'(bus.ringing), 32'd1);
        chk("ring_buzz",  32'(bus.buzz),    32'd1);

        pulse_tick();
        chk("tick1_buzz", 32'(bus.buzz), 32'd0);
        pulse_tick();
        chk("tick2_buzz", 32'(bus.buzz), 32'd1);
        pulse_tick();
        chk("tick3_buzz", 32'(bus.buzz),    32'd0);
        chk("tick3_ring", 32'(bus.ringing), 32'd1);
        pulse_tick();
        chk("timeout_ring",  32'(bus.ringing), 32'd0);
        chk("timeout_armed", 32'(bus.armed),   32'd1);
        chk("timeout_buzz",  32'(bus.buzz),    32'd0);
        cyc();
        cyc();
        chk("no_retrigger", 32'(bus.ringing), 32'd0);

        retrigger("retrig1");
        bus.snooze = 1'b1;
        cyc();
        bus.snooze = 1'b0;
        chk("snz_flag", 32'(bus.snoozing), 32'd1);
        chk("snz_buzz", 32'(bus.buzz),     32'd0);
        chk("snz_ring", 32'(bus.ringing),  32'd0);
        pulse_tick();
        pulse_tick();
        chk("snz_2tick", 32'(bus.snoozing), 32'd1);
        pulse_tick();
        chk("snz_resume", 32'(bus.ringing), 32'd1);
        chk("snz_rbuzz",  32'(bus.buzz),    32'd1);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("stop_armed", 32'(bus.armed),   32'd1);
        chk("stop_ring",  32'(bus.ringing), 32'd0);
        chk("stop_buzz",  32'(bus.buzz),    32'd0);

        retrigger("retrig2");
        bus.stop   = 1'b1;
        bus.snooze = 1'b1;
        cyc();
        bus.stop   = 1'b0;
        bus.snooze = 1'b0;
        chk("stopwin_snz",   32'(bus.snoozing), 32'd0);
        chk("stopwin_armed", 32'(bus.armed),    32'd1);
        chk("stopwin_ring",  32'(bus.ringing),  32'd0);

        retrigger("retrig3");
        bus.snooze = 1'b1;
        bus.tick   = 1'b1;
        cyc();
        bus.snooze = 1'b0;
        bus.tick   = 1'b0;
        chk("snztick_snz", 32'(bus.snoozing), 32'd1);
        bus.snooze = 1'b1;
        cyc();
        bus.snooze = 1'b0;
        chk("snz_in_snz", 32'(bus.snoozing), 32'd1);
        pulse_tick();
        pulse_tick();
        chk("snztick_2", 32'(bus.snoozing), 32'd1);
        pulse_tick();
        chk("snztick_3", 32'(bus.ringing), 32'd1);

        do_set(8'h13, 8'h00, 1'b0);
        chk("ring_set_err", 32'(bus.set_err),  32'd0);
        chk("ring_set_hh",  32'(bus.alarm_hh), 32'h07);
        do_set(8'h09, 8'h15, 1'b1);
        chk("ring_set_ign", 32'(bus.alarm_mm), 32'h30);

        bus.arm = 1'b0;
        cyc();
        chk("disarm_armed", 32'(bus.armed),    32'd0);
        chk("disarm_ring",  32'(bus.ringing),  32'd0);
        chk("disarm_snz",   32'(bus.snoozing), 32'd0);
        chk("disarm_buzz",  32'(bus.buzz),     32'd0);

        bus.arm = 1'b1;
        cyc();
        retrigger("retrig4");
        #3;
        reset = 1'b0;
        #1;
        chk("arst_buzz",  32'(bus.buzz),     32'd0);
        chk("arst_ring",  32'(bus.ringing),  32'd0);
        chk("arst_hh",    32'(bus.alarm_hh), 32'h12);
        chk("arst_mm",    32'(bus.alarm_mm), 32'h00);
        chk("arst_pm",    32'(bus.alarm_pm), 32'd0);
        chk("arst_armed", 32'(bus.armed),    32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm controller downstream of the 12-hour clock core. Consumes the core's BCD time (hh/mm/ss/pm) and the same 1 Hz enable pulse that advances the clock. Holds a user-programmed alarm time and runs an armed/ringing/snooze state machine. Drives a buzzer output and status flags for the display/top level.

Parameters:
RING_SECS, 60, ticks spent in RINGING before auto-timeout back to ARMED
SNOOZE_SECS, 300, ticks spent in SNOOZE before ringing resumes
CNT_W, 9, width of shared tick counter; must hold max(RING_SECS, SNOOZE_SECS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle 1 Hz pulse, same signal as the clock core's ena
hh  in  8  current hours, BCD 01-12
mm  in  8  current minutes, BCD 00-59
ss  in  8  current seconds, BCD 00-59
pm  in  1  current AM/PM flag, 1 = PM
arm  in  1  level; 1 = alarm enabled
set_en  in  1  one-cycle pulse; load set_hh/set_mm/set_pm into alarm registers
set_hh  in  8  alarm hours, BCD
set_mm  in  8  alarm minutes, BCD
set_pm  in  1  alarm AM/PM
snooze  in  1  one-cycle pulse
stop  in  1  one-cycle pulse
alarm_hh  out  8  stored alarm hours
alarm_mm  out  8  stored alarm minutes
alarm_pm  out  1  stored alarm AM/PM
armed  out  1  state is ARMED, RINGING or SNOOZE
ringing  out  1  state is RINGING
snoozing  out  1  state is SNOOZE
buzz  out  1  buzzer drive
set_err  out  1  one-cycle pulse on rejected set_en

Behaviour:
- Reset (reset=0, async):
  - state IDLE; alarm_hh=8'h12, alarm_mm=8'h00, alarm_pm=0.
  - counter=0; match_q=0.
  - armed, ringing, snoozing, buzz, set_err all 0.
- All outputs registered. States: IDLE, ARMED, RINGING, SNOOZE.
- Set:
  - set_en accepted only in IDLE/ARMED.
  - Valid range: set_hh BCD 01-12; set_mm BCD 00-59; both nibbles ≤9.
  - Valid set_en: registers update next edge.
  - Invalid set_en: registers unchanged; set_err=1 for one cycle.
  - set_en in RINGING/SNOOZE: ignored, no set_err.
- Match detection:
  - match = (hh==alarm_hh)&&(mm==alarm_mm)&&(pm==alarm_pm)&&(ss==8'h00).
  - match_q registers match every cycle.
  - Trigger = match & ~match_q (rising edge only), so one trigger per alarm minute.
- Priority order, highest first: arm=0 → IDLE (from any state; counter cleared, buzz=0); then stop; then snooze; then tick/timeout; then trigger.
- IDLE:
  - arm=1 → ARMED next edge.
  - A trigger pending at arming is not acted on until its next rising edge.
- ARMED: trigger → RINGING at the next edge (ringing high one cycle after the edge where inputs first match); counter=0, buzz=1.
- RINGING:
  - Each tick: counter+1 and buzz toggles.
  - Tick on which counter reaches RING_SECS-1 → ARMED, buzz=0, counter=0.
  - snooze → SNOOZE, counter=SNOOZE_SECS, buzz=0.
  - stop → ARMED, buzz=0.
  - stop+snooze in the same cycle: stop wins.
  - snooze+tick in the same cycle: snooze wins; tick not counted.
  - Trigger ignored.
- SNOOZE:
  - Each tick: counter-1.
  - Tick with counter==1 → RINGING, counter=0, buzz=1.
  - stop → ARMED. snooze ignored. Trigger ignored.
- Counter never wraps; arithmetic in CNT_W bits.
- reset asserted mid-ring: immediate IDLE, buzz=0 asynchronously; alarm time returns to 12:00 AM.

Test Plan:
- Reset → armed=0, ringing=0, buzz=0, alarm_hh=12, alarm_mm=00, alarm_pm=0. Then set_en with set_hh=13 → set_err pulse, registers unchanged. Then set_mm=8'h5A → set_err pulse.
- Set 07:30 AM, arm=1, drive time 07:29:59 AM → 07:30:00 AM:
  - ringing=1 one cycle after the match edge; buzz=1.
  - Same time with pm=1 → no trigger.
- Params RING_SECS=4: ring with no user input → buzz toggles 1,0,1,0 on ticks; after the 4th tick ringing=0, armed=1. Holding 07:30:00 does not retrigger.
- Params SNOOZE_SECS=3: ring, pulse snooze → snoozing=1, buzz=0; after 3 ticks ringing=1, buzz=1. Pulse stop → armed=1, ringing=0.
- Ringing, drive snooze and stop in the same cycle → ARMED (not SNOOZE). Ringing, snooze+tick in the same cycle → SNOOZE with counter=SNOOZE_SECS.
- Ringing, drop arm → IDLE next edge, all flags 0. Ringing, assert reset between clock edges → buzz=0 immediately, alarm registers back to 12:00 AM.
